// File: rtl/camera_data_gen_block.sv
// Synthetic image-sensor source. Each rising edge of en requests one frame
// of HEIGHT lines x WIDTH pixels using parallel camera framing.
module camera_data_gen_block #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_BLANK = 16,
  parameter int F_PORCH = 4,
  parameter int F_BACK  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       line_valid,
  output logic       frame_valid,
  output logic [9:0] pixel_data
);

  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  // One phase counter is shared by porch, blanking and back porch.
  localparam int PH_MAX = (F_PORCH > H_BLANK) ? ((F_PORCH > F_BACK) ? F_PORCH : F_BACK)
                                              : ((H_BLANK > F_BACK) ? H_BLANK : F_BACK);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {IDLE, PORCH, LINE, HBLANK, BACK} state_t;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [PH_W-1:0]  ph_reg, ph_next;
  logic [7:0]       frame_cnt_reg, frame_cnt_next;
  logic [9:0]       pixel_next;

  logic req_toggle_reg;
  logic sync1_reg, sync2_reg, hist_reg;
  logic pending_reg;
  logic req_seen;
  logic frame_start;

  // Toggle in the en domain so that even a sub-cycle pulse leaves a level change.
  always_ff @(posedge en or negedge rst_n) begin
    if (!rst_n) req_toggle_reg <= 1'b0;
    else        req_toggle_reg <= ~req_toggle_reg;
  end

  // Bring the toggle into clk and keep one history stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
    end else begin
      sync1_reg <= req_toggle_reg;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  assign req_seen    = sync2_reg ^ hist_reg;
  assign frame_start = (state_reg == IDLE) && pending_reg;

  // Hold requests until a frame starts; multiple requests merge into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_reg <= 1'b0;
    else        pending_reg <= req_seen | (pending_reg & ~frame_start);
  end

  // Next-state, counters and next output values.
  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    ph_next        = ph_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = PORCH;
          ph_next    = '0;
          col_next   = '0;
          row_next   = '0;
        end
      end
      PORCH: begin
        if (ph_reg == PH_W'(F_PORCH - 1)) begin
          state_next = LINE;
          col_next   = '0;
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      LINE: begin
        if (col_reg == COL_W'(WIDTH - 1)) begin
          state_next = HBLANK;
          ph_next    = '0;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
      HBLANK: begin
        if (ph_reg == PH_W'(H_BLANK - 1)) begin
          // Compare before incrementing so the row counter never overflows.
          if (row_reg == ROW_W'(HEIGHT - 1)) begin
            state_next = BACK;
            ph_next    = '0;
          end else begin
            row_next   = row_reg + 1'b1;
            col_next   = '0;
            state_next = LINE;
          end
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      BACK: begin
        if (ph_reg == PH_W'(F_BACK - 1)) begin
          state_next     = IDLE;
          frame_cnt_next = frame_cnt_reg + 8'd1;
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    pixel_next = '0;
    if (state_next == LINE)
      pixel_next = 10'(col_next) + 10'(row_next) + 10'(frame_cnt_next);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      col_reg       <= '0;
      row_reg       <= '0;
      ph_reg        <= '0;
      frame_cnt_reg <= '0;
      frame_valid   <= 1'b0;
      line_valid    <= 1'b0;
      pixel_data    <= '0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      ph_reg        <= ph_next;
      frame_cnt_reg <= frame_cnt_next;
      frame_valid   <= (state_next != IDLE);
      line_valid    <= (state_next == LINE);
      pixel_data    <= pixel_next;
    end
  end

endmodule

// File: tb/tb_camera_data_gen_block.sv
// Self-checking bench for camera_data_gen_block with a small frame geometry.
module tb_camera_data_gen_block;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int HB  = 2;
  localparam int FP  = 4;
  localparam int FB  = 4;
  localparam int LP  = W + HB;
  localparam int ACT = H * LP;
  localparam int FLEN = FP + ACT + FB;   // 48

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       line_valid;
  logic       frame_valid;
  logic [9:0] pixel_data;

  camera_data_gen_block #(
    .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .F_PORCH(FP), .F_BACK(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .line_valid(line_valid), .frame_valid(frame_valid), .pixel_data(pixel_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Edge counter: value n means n rising edges have occurred.
  int cycle = 0;
  always @(posedge clk) cycle++;

  // Reference model: request ready edges and frame timeline.
  int req_q[$];
  int in_frame = 0;
  int fs = 0;
  int fc = 0;
  int idle_avail = 0;

  // Observed-waveform bookkeeping.
  int prev_fv = 0, prev_lv = 0;
  int fv_run = 0, low_run = 0, lv_run = 0, lv_pulses = 0;
  int rises = 0, frames_seen = 0, last_gap = -1;
  int first_pend = 0, first_pix = -1, last_pix = -1, prev_pix = 0;

  always @(negedge clk) begin
    int n, o, p, r, c, has;
    logic       e_fv, e_lv;
    logic [9:0] e_pix;
    n = cycle;
    if (in_frame != 0 && n - fs == FLEN) begin
      in_frame   = 0;
      fc         = (fc + 1) % 256;
      idle_avail = n + 1;
    end
    if (in_frame == 0 && n >= idle_avail) begin
      has = 0;
      foreach (req_q[i]) if (req_q[i] <= n) has = 1;
      if (has != 0) begin
        in_frame = 1;
        fs = n;
        for (int i = req_q.size() - 1; i >= 0; i--)
          if (req_q[i] <= n) req_q.delete(i);
      end
    end
    e_fv = 1'b0; e_lv = 1'b0; e_pix = '0;
    if (in_frame != 0) begin
      o = n - fs;
      e_fv = 1'b1;
      if (o >= FP && o < FP + ACT) begin
        p = o - FP;
        r = p / LP;
        c = p % LP;
        if (c < W) begin
          e_lv  = 1'b1;
          e_pix = 10'((c + r + fc) % 1024);
        end
      end
    end
    check("frame_valid", frame_valid, e_fv);
    check("line_valid", line_valid, e_lv);
    check("pixel_data", pixel_data, e_pix);

    // Spec-level framing rules measured directly on the waveform.
    if (frame_valid && prev_fv == 0) begin
      rises++;
      last_gap   = low_run;
      lv_pulses  = 0;
      first_pend = 1;
    end
    if (!frame_valid && prev_fv != 0) begin
      frames_seen++;
      check("frame_len", fv_run, FLEN);
      check("line_count", lv_pulses, H);
      $display("frame %0d done at cycle %0d, length %0d, lines %0d", frames_seen, n, fv_run, lv_pulses);
    end
    if (line_valid && prev_lv == 0) begin
      lv_pulses++;
      if (first_pend != 0) begin
        first_pix  = pixel_data;
        first_pend = 0;
      end
    end
    if (!line_valid && prev_lv != 0) begin
      check("line_len", lv_run, W);
      last_pix = prev_pix;
    end
    fv_run  = frame_valid ? ((prev_fv != 0) ? fv_run + 1 : 1) : 0;
    low_run = frame_valid ? 0 : ((prev_fv == 0) ? low_run + 1 : 1);
    lv_run  = line_valid ? ((prev_lv != 0) ? lv_run + 1 : 1) : 0;
    prev_fv  = frame_valid ? 1 : 0;
    prev_lv  = line_valid ? 1 : 0;
    prev_pix = pixel_data;
  end

  // Short en pulse a few ns after a rising edge, asynchronous to clk.
  task automatic pulse_en();
    int d;
    @(posedge clk);
    d = $urandom_range(1, 3);
    #d;
    req_q.push_back(cycle + 4);
    en = 1'b1;
    #1 en = 1'b0;
    $display("en pulse after cycle %0d, frame start expected no earlier than edge %0d", cycle, cycle + 4);
  endtask

  task automatic wait_quiet(input int max_cycles);
    int k = 0;
    while ((in_frame != 0 || req_q.size() != 0) && k < max_cycles) begin
      @(posedge clk);
      k++;
    end
    check("quiet_in_time", (k < max_cycles) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n      = 1'b0;
    in_frame   = 0;
    fc         = 0;
    idle_avail = 0;
    req_q.delete();
    prev_fv = 0; prev_lv = 0; fv_run = 0; lv_run = 0; first_pend = 0;
    #1;
    check("rst_fv", frame_valid, 0);
    check("rst_lv", line_valid, 0);
    check("rst_pix", pixel_data, 0);
  endtask

  initial begin
    int base, k, np, rises_at_rst;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("init_fv", frame_valid, 0);
    check("init_lv", line_valid, 0);
    check("init_pix", pixel_data, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // No request: stay idle.
    repeat (1000) @(posedge clk);
    check("idle_no_frame", rises, 0);

    // First frame.
    pulse_en();
    wait_quiet(500);
    check("frames_after_1", frames_seen, 1);
    check("f1_first_pix", first_pix, 0);
    check("f1_last_pix", last_pix, 10);

    // Second frame, frame counter now 1.
    pulse_en();
    wait_quiet(500);
    check("frames_after_2", frames_seen, 2);
    check("f2_first_pix", first_pix, 1);
    check("f2_last_pix", last_pix, 11);

    // Two requests during one frame -> exactly one extra back-to-back frame.
    base = frames_seen;
    pulse_en();
    k = 0;
    while (in_frame == 0 && k < 100) begin @(posedge clk); k++; end
    check("f3_started", (k < 100) ? 1 : 0, 1);
    repeat (10) @(posedge clk);
    pulse_en();
    repeat (5) @(posedge clk);
    pulse_en();
    wait_quiet(500);
    check("b2b_frames", frames_seen - base, 2);
    check("b2b_gap", last_gap, 1);

    // Random request bursts.
    for (int it = 0; it < 8; it++) begin
      np = $urandom_range(1, 3);
      for (int j = 0; j < np; j++) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        pulse_en();
      end
      if ($urandom_range(0, 1) == 1) wait_quiet(1000);
    end
    wait_quiet(2000);

    // Reset in the middle of a line.
    pulse_en();
    k = 0;
    while (!line_valid && k < 100) begin @(negedge clk); k++; end
    check("pre_rst_in_line", line_valid, 1);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    do_reset();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
    rises_at_rst = rises;
    repeat (100) @(posedge clk);
    check("post_rst_idle", rises, rises_at_rst);
    pulse_en();
    wait_quiet(500);
    check("post_rst_first_pix", first_pix, 0);
    check("post_rst_last_pix", last_pix, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/camera_data_gen_block.md
# camera_data_gen_block

Module `camera_data_gen` is a synthetic image-sensor source for the histogram pipeline. Each start request on `en` produces one complete frame of `HEIGHT` lines × `WIDTH` pixels. The frame uses the camera's parallel framing: `frame_valid`, `line_valid`, and 10-bit `pixel_data`. The block stands in for the real sensor during simulation and bring-up, feeding the same downstream capture logic.

## Interface
- `WIDTH`, 640: active pixels per line.
- `HEIGHT`, 480: active lines per frame.
- `H_BLANK`, 16: idle cycles after each line, with `line_valid` low and `frame_valid` still high.
- `F_PORCH`, 4: cycles with `frame_valid` high before the first line.
- `F_BACK`, 4: cycles with `frame_valid` high after the last line's `H_BLANK`.
- `clk`  in  1: single clock. All outputs are registered on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: start request, triggered by its rising edge. The pulse may be shorter than one `clk` period and is asynchronous to `clk`.
- `line_valid`  out  1: high while active pixels of a line are driven.
- `frame_valid`  out  1: high for the whole frame, from porch through back porch.
- `pixel_data`  out  10: pixel value. Valid only while `line_valid` is high; 0 otherwise.

## Operation
- Request capture:
  - A toggle flop clocked by `en` inverts on every rising edge of `en`. `rst_n` clears it.
  - The toggle passes through a 2-flop synchronizer into `clk`, plus one history flop.
  - A request is detected when sync2 differs from history.
  - Any `en` edge of nonzero width must register.
- Start latching:
  - A detected request sets `pending`.
  - `pending` is cleared when a frame starts.
  - Several requests before a frame starts collapse into one frame.
- FSM states: IDLE, PORCH, LINE, HBLANK, BACK.
  - IDLE: when `pending` is set, go to PORCH and raise `frame_valid`.
  - PORCH: after `F_PORCH` cycles, go to LINE.
  - LINE: `line_valid` is high for exactly `WIDTH` cycles. The column counter runs 0..`WIDTH`-1. Then go to HBLANK.
  - HBLANK: `H_BLANK` cycles. Then increment the row counter. If row < `HEIGHT`, return to LINE; otherwise go to BACK.
  - BACK: `F_BACK` cycles. Then go to IDLE, drop `frame_valid`, and increment the frame counter.
- Pixel value:
  - `pixel_data` = (col + row + frame_cnt) mod 1024.
  - `frame_cnt` is 8-bit, wraps at 255→0, and is zero-extended.
  - col and row restart at 0 every frame.
- Counter widths: `$clog2` of the parameter. Each counter is at least 1 bit.
- Re-start behaviour:
  - A request arriving mid-frame sets `pending`.
  - The next frame then starts on the cycle after IDLE is entered.
  - `frame_valid` is low for exactly 1 cycle between back-to-back frames.
- Reset:
  - `rst_n` low forces the FSM to IDLE.
  - All counters, `pending`, the synchronizer and the toggle are cleared.
  - All outputs go to 0 immediately.
  - A reset in mid-frame aborts the frame. Nothing resumes after release.

## Timing
- Reset values: `frame_valid`=0, `line_valid`=0, `pixel_data`=0.
- Start latency: `frame_valid` rises on the 4th rising `clk` edge after the `en` rising edge. The breakdown is:
  - edges 1 and 2: synchronizer;
  - edge 3: `pending` set;
  - edge 4: FSM leaves IDLE.
- `line_valid` first rises `F_PORCH` cycles after `frame_valid` rises.
- `pixel_data` changes on the same edge as `line_valid`. The first pixel of each line is (0 + row + frame_cnt).
- Line period = `WIDTH` + `H_BLANK` cycles.
- Frame length (`frame_valid` high) = `F_PORCH` + `HEIGHT`×(`WIDTH` + `H_BLANK`) + `F_BACK` cycles. With default parameters this is 314888 cycles.
- `line_valid` is never high while `frame_valid` is low.
- `frame_valid` falls exactly `F_BACK` cycles after the final HBLANK ends.

## Test plan
- Reset with `en` idle → all outputs 0. The outputs stay 0 for 1000 cycles; no frame without a request.
- WIDTH=8, HEIGHT=4, H_BLANK=2, F_PORCH=4, F_BACK=4; 1 ns `en` pulse between clock edges:
  - `frame_valid` rises on the 4th edge and stays high 4+4×10+4 = 48 cycles;
  - 4 `line_valid` pulses of 8 cycles each;
  - row 2 data is 2,3,…,9.
- Second request after the first frame ends:
  - `frame_cnt` is 1;
  - first pixel of frame 2 is 1;
  - last pixel is (7+3+1) = 11.
- Two `en` pulses during one frame → exactly one additional frame follows, with a 1-cycle `frame_valid` low gap.
- `rst_n` asserted mid-line:
  - outputs go to 0 asynchronously, before the next edge;
  - after release, no activity until a new `en` edge;
  - the next frame starts with `frame_cnt`=0.
- Default parameters, 2 requests → each frame has 480 lines of 640 pixels and `frame_valid` high 314888 cycles. The simulation ends after the second `frame_valid` fall.
